// File: rtl/typewriter_write_if.sv
// Keyboard-to-character-buffer bus of the VGA typewriter. The controller
// takes the slave side; the keyboard/display side takes the master side.
interface typewriter_write_if #(
  parameter int GRID_COL    = 10,
  parameter int GRID_ROW    = 5,
  parameter int ADDR_WIDTH  = 11,
  parameter int ASCII_WIDTH = 8
);
  localparam int ROW_W = (GRID_ROW > 1) ? $clog2(GRID_ROW) : 1;
  localparam int COL_W = (GRID_COL > 1) ? $clog2(GRID_COL) : 1;

  logic [ASCII_WIDTH-1:0] asciiIn;
  logic                   dataReady;
  logic                   clearReq;
  logic [ADDR_WIDTH-1:0]  writeAddr;
  logic [ASCII_WIDTH-1:0] writeData;
  logic                   writeEn;
  logic [ROW_W-1:0]       cursorRow;
  logic [COL_W-1:0]       cursorCol;
  logic                   busy;

  modport master (
    output asciiIn, dataReady, clearReq,
    input  writeAddr, writeData, writeEn, cursorRow, cursorCol, busy
  );

  modport slave (
    input  asciiIn, dataReady, clearReq,
    output writeAddr, writeData, writeEn, cursorRow, cursorCol, busy
  );
endinterface

// File: rtl/typewriter_write_ctrl.sv
// Write sequencer for the typewriter character buffer: key events, cursor, clear sweep.
// Optional macro TYPEWRITER_CLEAR_ON_WRAP_EN: a wrap from the last row back to row 0 triggers a clear.
module typewriter_write_ctrl #(
  parameter int GRID_COL    = 10,
  parameter int GRID_ROW    = 5,
  parameter int ADDR_WIDTH  = 11,
  parameter int ASCII_WIDTH = 8
) (
  input  logic               clk_pix,
  input  logic               rst,
  typewriter_write_if.slave  bus
);

  localparam int ROW_W = (GRID_ROW > 1) ? $clog2(GRID_ROW) : 1;
  localparam int COL_W = (GRID_COL > 1) ? $clog2(GRID_COL) : 1;
  localparam int CELLS = GRID_COL * GRID_ROW;
  localparam int CNT_W = $clog2(CELLS + 1);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GRID_ROW - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(GRID_COL - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CELLS);

  localparam logic [ASCII_WIDTH-1:0] CH_SPACE = ASCII_WIDTH'(32'h20);
  localparam logic [ASCII_WIDTH-1:0] CH_TILDE = ASCII_WIDTH'(32'h7E);
  localparam logic [ASCII_WIDTH-1:0] CH_LF    = ASCII_WIDTH'(32'h0A);
  localparam logic [ASCII_WIDTH-1:0] CH_CR    = ASCII_WIDTH'(32'h0D);
  localparam logic [ASCII_WIDTH-1:0] CH_BS    = ASCII_WIDTH'(32'h08);

`ifdef TYPEWRITER_CLEAR_ON_WRAP_EN
  localparam bit CLEAR_ON_WRAP = 1'b1;
`else
  localparam bit CLEAR_ON_WRAP = 1'b0;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic                   we;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [ASCII_WIDTH-1:0] data;
    logic [ROW_W-1:0]       row;
    logic [COL_W-1:0]       col;
    logic                   wrap;
  } key_act_t;

  function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                      input logic [COL_W-1:0] c);
    return ADDR_WIDTH'(int'(r) * GRID_COL + int'(c));
  endfunction

  // Decodes one key against the current cursor: what to write and where the cursor goes.
  function automatic key_act_t key_action(input logic [ASCII_WIDTH-1:0] code,
                                          input logic [ROW_W-1:0]       r,
                                          input logic [COL_W-1:0]       c);
    key_act_t a;
    a      = '0;
    a.row  = r;
    a.col  = c;
    a.addr = cell_addr(r, c);
    a.data = code;
    if (code >= CH_SPACE && code <= CH_TILDE) begin
      a.we = 1'b1;
      if (c == COL_LAST) begin
        a.col = '0;
        if (r == ROW_LAST) begin
          a.row  = '0;
          a.wrap = 1'b1;
        end else begin
          a.row = r + 1'b1;
        end
      end else begin
        a.col = c + 1'b1;
      end
    end else if (code == CH_LF || code == CH_CR) begin
      a.col = '0;
      if (r == ROW_LAST) begin
        a.row  = '0;
        a.wrap = 1'b1;
      end else begin
        a.row = r + 1'b1;
      end
    end else if (code == CH_BS) begin
      a.we   = 1'b1;
      a.data = CH_SPACE;
      if (c != '0) begin
        a.col = c - 1'b1;
      end else if (r != '0) begin
        a.row = r - 1'b1;
        a.col = COL_LAST;
      end
      a.addr = cell_addr(a.row, a.col);
    end
    return a;
  endfunction

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ASCII_WIDTH-1:0] data_q, data_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [ASCII_WIDTH-1:0] pend_code_q, pend_code_d;
  logic                   dr_prev_q, dr_prev_d;
  logic                   clr_prev_q, clr_prev_d;

  logic     key_ev;
  logic     clr_ev;
  key_act_t act;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_code_d = pend_code_q;
    dr_prev_d   = bus.dataReady;
    clr_prev_d  = bus.clearReq;

    key_ev = bus.dataReady & ~dr_prev_q;
    clr_ev = bus.clearReq & ~clr_prev_q;
    // A parked key always takes precedence over the live input on the first idle cycle.
    act    = key_action(pend_vld_q ? pend_code_q : bus.asciiIn, row_q, col_q);

    case (state_q)
      IDLE: begin
        if (clr_ev) begin
          // The first sweep write goes out on the entry edge so writeEn lines up with busy.
          state_d = CLEAR;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = CH_SPACE;
          cnt_d   = CNT_W'(1);
          if (key_ev && !pend_vld_q) begin
            pend_vld_d  = 1'b1;
            pend_code_d = bus.asciiIn;
          end
        end else if (pend_vld_q || key_ev) begin
          if (act.we) begin
            we_d   = 1'b1;
            addr_d = act.addr;
            data_d = act.data;
          end
          row_d = act.row;
          col_d = act.col;
          if (CLEAR_ON_WRAP && act.wrap) begin
            state_d = CLEAR;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
          if (pend_vld_q) begin
            pend_vld_d = key_ev;
            if (key_ev) pend_code_d = bus.asciiIn;
          end
        end
      end

      CLEAR: begin
        if (key_ev && !pend_vld_q) begin
          pend_vld_d  = 1'b1;
          pend_code_d = bus.asciiIn;
        end
        if (cnt_q != CNT_END) begin
          we_d   = 1'b1;
          addr_d = ADDR_WIDTH'(cnt_q);
          data_d = CH_SPACE;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          row_d   = '0;
          col_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_code_q <= '0;
      dr_prev_q   <= 1'b0;
      clr_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_code_q <= pend_code_d;
      dr_prev_q   <= dr_prev_d;
      clr_prev_q  <= clr_prev_d;
    end
  end

  assign bus.writeEn   = we_q;
  assign bus.writeAddr = addr_q;
  assign bus.writeData = data_q;
  assign bus.cursorRow = row_q;
  assign bus.cursorCol = col_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_typewriter_write_ctrl.sv
// Self-checking bench for typewriter_write_ctrl against a linear-position cursor model.
module tb_typewriter_write_ctrl;

  localparam int GC    = 10;
  localparam int GR    = 5;
  localparam int CELLS = GC * GR;

`ifdef TYPEWRITER_CLEAR_ON_WRAP_EN
  localparam bit CLEAR_ON_WRAP = 1'b1;
`else
  localparam bit CLEAR_ON_WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_row  = 0;
  int   exp_col  = 0;

  always #5 clk = ~clk;

  typewriter_write_if #(.GRID_COL(GC), .GRID_ROW(GR), .ADDR_WIDTH(11), .ASCII_WIDTH(8)) bus ();

  typewriter_write_ctrl #(.GRID_COL(GC), .GRID_ROW(GR), .ADDR_WIDTH(11), .ASCII_WIDTH(8)) dut (
    .clk_pix (clk),
    .rst     (rst),
    .bus     (bus)
  );

  // Reference: the cursor is a linear cell index; rows/cols are derived from it.
  task automatic model_key(input logic [7:0] code, output logic we, output logic [10:0] addr,
                           output logic [7:0] data, output logic wrap);
    int pos;
    pos  = exp_row * GC + exp_col;
    we   = 1'b0;
    addr = '0;
    data = '0;
    wrap = 1'b0;
    if (code >= 8'h20 && code <= 8'h7E) begin
      we   = 1'b1;
      addr = 11'(pos);
      data = code;
      wrap = (pos == CELLS - 1);
      pos  = (pos + 1) % CELLS;
      exp_row = pos / GC;
      exp_col = pos % GC;
    end else if (code == 8'h0A || code == 8'h0D) begin
      wrap    = (exp_row == GR - 1);
      exp_row = (exp_row + 1) % GR;
      exp_col = 0;
    end else if (code == 8'h08) begin
      if (pos > 0) pos--;
      we   = 1'b1;
      addr = 11'(pos);
      data = 8'h20;
      exp_row = pos / GC;
      exp_col = pos % GC;
    end
  endtask

  // Called at the sample point of the first sweep write; returns at the first idle sample.
  task automatic check_sweep(input string name);
    for (int i = 0; i < CELLS; i++) begin
      n_checks++;
      if (bus.writeEn !== 1'b1 || bus.writeAddr !== 11'(i) || bus.writeData !== 8'h20 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s sweep[%0d]: got we=%0b addr=%0d data=%0h busy=%0b, expected we=1 addr=%0d data=20 busy=1",
                 name, i, bus.writeEn, bus.writeAddr, bus.writeData, bus.busy, i);
      end
      @(posedge clk); #1;
    end
    exp_row = 0;
    exp_col = 0;
    n_checks++;
    if (bus.writeEn !== 1'b0 || bus.busy !== 1'b0 || bus.cursorRow !== 3'd0 || bus.cursorCol !== 4'd0) begin
      n_fail++;
      $display("FAIL %s sweep_end: got we=%0b busy=%0b cursor=%0d,%0d, expected we=0 busy=0 cursor=0,0",
               name, bus.writeEn, bus.busy, bus.cursorRow, bus.cursorCol);
    end
  endtask

  task automatic send_key(input logic [7:0] code, input string name);
    logic        we;
    logic [10:0] addr;
    logic [7:0]  data;
    logic        wrap;
    model_key(code, we, addr, data, wrap);
    @(negedge clk);
    bus.asciiIn   = code;
    bus.dataReady = 1'b1;
    @(posedge clk); #1;
    bus.dataReady = 1'b0;
    n_checks++;
    if (bus.writeEn !== we || (we && (bus.writeAddr !== addr || bus.writeData !== data)) ||
        bus.cursorRow !== 3'(exp_row) || bus.cursorCol !== 4'(exp_col)) begin
      n_fail++;
      $display("FAIL %s key %0h: got we=%0b addr=%0d data=%0h cursor=%0d,%0d, expected we=%0b addr=%0d data=%0h cursor=%0d,%0d",
               name, code, bus.writeEn, bus.writeAddr, bus.writeData, bus.cursorRow, bus.cursorCol,
               we, addr, data, exp_row, exp_col);
    end
    if (CLEAR_ON_WRAP && wrap) begin
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s wrap_busy: got busy=%0b, expected 1", name, bus.busy);
      end
      @(posedge clk); #1;
      check_sweep(name);
    end else begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.writeEn !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s strobe_end: got we=%0b busy=%0b, expected we=0 busy=0", name, bus.writeEn, bus.busy);
      end
    end
  endtask

  task automatic start_clear(input string name);
    @(negedge clk);
    bus.clearReq = 1'b1;
    @(posedge clk); #1;
    bus.clearReq = 1'b0;
    check_sweep(name);
  endtask

  task automatic check_pending(input logic [7:0] code, input string name);
    logic        we;
    logic [10:0] addr;
    logic [7:0]  data;
    logic        wrap;
    model_key(code, we, addr, data, wrap);
    @(posedge clk); #1;
    n_checks++;
    if (bus.writeEn !== we || bus.writeAddr !== addr || bus.writeData !== data ||
        bus.cursorRow !== 3'(exp_row) || bus.cursorCol !== 4'(exp_col)) begin
      n_fail++;
      $display("FAIL %s pending: got we=%0b addr=%0d data=%0h cursor=%0d,%0d, expected we=%0b addr=%0d data=%0h cursor=%0d,%0d",
               name, bus.writeEn, bus.writeAddr, bus.writeData, bus.cursorRow, bus.cursorCol,
               we, addr, data, exp_row, exp_col);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.writeEn !== 1'b0 || bus.cursorRow !== 3'(exp_row) || bus.cursorCol !== 4'(exp_col)) begin
      n_fail++;
      $display("FAIL %s pending_after: got we=%0b cursor=%0d,%0d, expected we=0 cursor=%0d,%0d",
               name, bus.writeEn, bus.cursorRow, bus.cursorCol, exp_row, exp_col);
    end
  endtask

  task automatic test_reset();
    bus.asciiIn   = '0;
    bus.dataReady = 1'b0;
    bus.clearReq  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.writeEn, bus.writeAddr, bus.writeData, bus.cursorRow, bus.cursorCol, bus.busy} !== '0) begin
      n_fail++;
      $display("FAIL reset: got we=%0b addr=%0d data=%0h cursor=%0d,%0d busy=%0b, expected all zero",
               bus.writeEn, bus.writeAddr, bus.writeData, bus.cursorRow, bus.cursorCol, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_row = 0;
    exp_col = 0;
  endtask

  task automatic test_printable();
    send_key(8'h41, "first_key");
    for (int i = 0; i < 8; i++) send_key(8'($urandom_range(32, 126)), "printable");
    send_key(8'h42, "end_of_row");
  endtask

  task automatic test_backspace();
    send_key(8'h08, "bs_row_back");
    for (int i = 0; i < 9; i++) send_key(8'h08, "bs_walk");
    send_key(8'h08, "bs_origin");
  endtask

  task automatic test_newline();
    for (int i = 0; i < 3; i++) send_key(8'h0A, "lf");
    for (int i = 0; i < 5; i++) send_key(8'($urandom_range(32, 126)), "fill");
    send_key(8'h0D, "cr");
    send_key(8'h07, "ignored");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 9; i++) send_key(8'($urandom_range(32, 126)), "last_row");
    send_key(8'h5A, "wrap_cell");
  endtask

  task automatic test_clear();
    if (exp_row != 0 || exp_col != 0) start_clear("clear_home");
    send_key(8'h0A, "to_r1");
    send_key(8'h0A, "to_r2");
    for (int i = 0; i < 3; i++) send_key(8'($urandom_range(32, 126)), "to_c3");
    start_clear("clear");
  endtask

  task automatic test_pending();
    fork
      start_clear("pend_clear");
      begin
        repeat (4) @(negedge clk);
        bus.asciiIn   = 8'h43;
        bus.dataReady = 1'b1;
        @(negedge clk);
        bus.dataReady = 1'b0;
        repeat (3) @(negedge clk);
        bus.asciiIn   = 8'h44;
        bus.dataReady = 1'b1;
        @(negedge clk);
        bus.dataReady = 1'b0;
      end
    join
    check_pending(8'h43, "pend_keep_first");
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    bus.asciiIn   = 8'h55;
    bus.dataReady = 1'b1;
    bus.clearReq  = 1'b1;
    @(posedge clk); #1;
    bus.dataReady = 1'b0;
    bus.clearReq  = 1'b0;
    check_sweep("same_cycle");
    check_pending(8'h55, "same_cycle");
  endtask

  task automatic test_random();
    logic [7:0] code;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        6:       code = 8'h0A;
        7:       code = 8'h0D;
        8:       code = 8'h08;
        9: begin
          code = 8'($urandom_range(0, 31));
          if (code == 8'h08 || code == 8'h0A || code == 8'h0D) code = 8'h7F;
        end
        default: code = 8'($urandom_range(32, 126));
      endcase
      send_key(code, "random");
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    bus.clearReq = 1'b1;
    @(posedge clk); #1;
    bus.clearReq = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.writeEn, bus.writeAddr, bus.writeData, bus.cursorRow, bus.cursorCol, bus.busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_sweep: got we=%0b addr=%0d data=%0h cursor=%0d,%0d busy=%0b, expected all zero",
               bus.writeEn, bus.writeAddr, bus.writeData, bus.cursorRow, bus.cursorCol, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_row = 0;
    exp_col = 0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.writeEn !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_idle: got we=%0b busy=%0b, expected 0,0", bus.writeEn, bus.busy);
    end
    send_key(8'h61, "after_reset");
  endtask

  initial begin
    test_reset();
    test_printable();
    test_backspace();
    test_newline();
    test_wrap();
    test_clear();
    test_pending();
    test_same_cycle();
    test_random();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/typewriter_write_ctrl.md
Name: typewriter_write_ctrl

Overview:
- Sequences all writes into the character buffer of the VGA typewriter display.
- Turns keyboard ASCII events into buffer writes and keeps the text cursor (row/col).
- Handles printable characters, newline, backspace and a full-screen clear sweep.
- Sits between the keyboard decoder and the display logic's write port (address, data, write enable), all in the pixel clock domain.

Parameters:
GRID_COL, 10, characters per row (640/(8*8))
GRID_ROW, 5, character rows (480/(11*8))
ADDR_WIDTH, 11, buffer address width; GRID_COL*GRID_ROW must be <= 2**ADDR_WIDTH
ASCII_WIDTH, 8, character code width

Ports:
clk_pix  in  1  pixel clock; the only clock
rst  in  1  asynchronous, active-high reset
asciiIn  in  ASCII_WIDTH  character code, valid while dataReady high
dataReady  in  1  level strobe; a rising edge is one key event
clearReq  in  1  level; a rising edge requests a screen clear
writeAddr  out  ADDR_WIDTH  buffer address, row*GRID_COL+col
writeData  out  ASCII_WIDTH  character to store
writeEn  out  1  one-cycle write strobe
cursorRow  out  clog2(GRID_ROW)  current cursor row
cursorCol  out  clog2(GRID_COL)  current cursor column
busy  out  1  high while in CLEAR state

Behaviour:
- Reset (async, rst=1): writeEn=0, writeAddr=0, writeData=0, cursorRow=0, cursorCol=0, busy=0. State=IDLE, pending slot empty, edge-detect registers cleared.
  - The first high sample of dataReady or clearReq after reset counts as an edge.
- Edge detection: registered copies of dataReady and clearReq; event = input & ~previous.
- States: IDLE, CLEAR.
- IDLE, key event seen in cycle N: the action is registered at the end of N. writeEn/writeAddr/writeData are valid in cycle N+1, and the cursor updates on the same edge.
  - Printable 0x20-0x7E: write asciiIn at the cursor, then col+1.
    - If col==GRID_COL-1: col=0, row+1.
    - At the last row and last column: row=0, col=0 (wrap to top).
  - 0x0A or 0x0D: no write; col=0, row+1 (row GRID_ROW-1 wraps to 0).
  - 0x08 backspace: move back one cell, then write 0x20 at the new position.
    - col>0: col-1.
    - col==0, row>0: row-1, col=GRID_COL-1.
    - At 0,0: no move, write 0x20 at address 0.
  - Any other code: ignored; no write, no cursor change.
- Clear event: enter CLEAR on the next edge; busy=1.
  - Writes 0x20 to addresses 0..GRID_COL*GRID_ROW-1, one per cycle, writeEn high continuously.
  - After the last address: cursor=0,0, busy=0, back to IDLE.
  - A clear of 5x10 cells takes 50 cycles of writeEn.
- Clear event and key event in the same cycle: clear wins; the key goes to the pending slot.
- Key event during CLEAR: stored in a one-deep pending slot.
  - If the slot is already full, the new key is dropped and the old one kept.
  - The pending key is processed in the first IDLE cycle after CLEAR, against cursor 0,0.
  - A new key event in that same cycle goes to the pending slot.
- Clear event during CLEAR: ignored; the sweep is not restarted.
- rst asserted mid-sweep: immediate return to reset values; the buffer is left partially cleared.
- Outside write cycles, writeEn=0 and writeAddr/writeData hold their last values.

Optional Feature:
- Macro: TYPEWRITER_CLEAR_ON_WRAP_EN.
- Defined: when a printable character or newline would wrap the cursor from the last row back to row 0:
  - The character write is still done.
  - The controller then enters CLEAR automatically (busy=1), exactly as for a clearReq edge, and ends at 0,0.
- Undefined: the cursor wraps to 0,0 silently and old text stays until overwritten.

Test Plan:
- Reset, then dataReady rising edge with asciiIn=0x41 -> one cycle later writeEn=1, writeAddr=0, writeData=0x41; cursor=0,1.
- Nine printable keys then 0x42 at col 9, row 0 -> write at addr 9; cursor=1,0. With the cursor at 4,9 -> write at addr 49; cursor=0,0 (macro off) or 50-cycle clear follows (macro on).
- Cursor 1,0, key 0x08 -> writeAddr=9, writeData=0x20, cursor=0,9. Cursor 0,0, key 0x08 -> write 0x20 at addr 0, cursor stays 0,0.
- clearReq edge with cursor 2,3 -> busy=1; 50 consecutive writeEn cycles with addr 0..49 and data 0x20; then busy=0, cursor=0,0.
- During CLEAR, keys 0x43 then 0x44 -> after the sweep, a single write of 0x43 at addr 0, cursor=0,1; 0x44 dropped.
- Key 0x0D at cursor 3,5 -> no writeEn, cursor=4,0. Key 0x07 -> no writeEn, cursor unchanged. rst asserted mid-clear -> all outputs at reset values the same cycle.
